// File: rtl/clipper_win_ctrl.sv
// Clipper window controller: measures frame size, holds one pending window write and
// commits it (clamped/validated) at the start of the next frame. Optional macro: CLIPPER_WIN_CTRL_CENTER_EN.
module clipper_win_ctrl #(
  parameter int DW       = 12,
  parameter bit ERR_HOLD = 1'b0
) (
  input  logic          pclk,
  input  logic          prst_n,
  input  logic          invsync,
  input  logic          inde,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_top,
  input  logic [DW-1:0] cfg_left,
  input  logic [DW-1:0] cfg_width,
  input  logic [DW-1:0] cfg_height,
`ifdef CLIPPER_WIN_CTRL_CENTER_EN
  input  logic          cfg_center,
`endif
  output logic [DW-1:0] clipper_top,
  output logic [DW-1:0] clipper_left,
  output logic [DW-1:0] clipper_width,
  output logic [DW-1:0] clipper_height,
  output logic [DW-1:0] frame_width,
  output logic [DW-1:0] frame_height,
  output logic          frame_valid,
  output logic          cfg_pending,
  output logic          cfg_err
);

  localparam logic [DW-1:0] ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, CHECK = 2'd2, COMMIT = 2'd3} state_t;

  state_t        state_r, state_nxt_s;
  logic          vs_r, vs_d_r, de_r, de_d_r;
  logic          vs_rise_s, de_fall_s;
  logic [DW-1:0] hcnt_r, lcnt_r, line_w_r;
  logic [DW-1:0] frame_width_r, frame_height_r;
  logic          frame_valid_r, cfg_ready_r, cfg_pending_r, cfg_err_r;
  logic [DW-1:0] p_top_r, p_left_r, p_w_r, p_h_r;
  logic          p_center_r, center_s;
  logic [DW-1:0] win_top_r, win_left_r, win_w_r, win_h_r;
  logic          win_err_r;
  logic [DW-1:0] clip_top_r, clip_left_r, clip_w_r, clip_h_r;
  logic          xfer_s, check_s, commit_s;
  logic [DW-1:0] req_w_s, req_h_s, avail_w_s, avail_h_s;
  logic [DW-1:0] c_top_s, c_left_s, c_w_s, c_h_s;
  logic          c_err_s;

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    sat_inc = (&v) ? v : v + ONE;
  endfunction

  assign vs_rise_s = vs_r & ~vs_d_r;
  assign de_fall_s = ~de_r & de_d_r;

`ifdef CLIPPER_WIN_CTRL_CENTER_EN
  assign center_s = p_center_r;
`else
  assign center_s = 1'b0;
`endif

  // Input sampling and edge history
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      vs_r   <= 1'b0;
      vs_d_r <= 1'b0;
      de_r   <= 1'b0;
      de_d_r <= 1'b0;
    end else begin
      vs_r   <= invsync;
      vs_d_r <= vs_r;
      de_r   <= inde;
      de_d_r <= de_r;
    end
  end

  // Frame geometry measurement; width is taken from the last line before vsync
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      hcnt_r         <= ZERO;
      lcnt_r         <= ZERO;
      line_w_r       <= ZERO;
      frame_width_r  <= ZERO;
      frame_height_r <= ZERO;
      frame_valid_r  <= 1'b0;
    end else begin
      hcnt_r <= de_r ? sat_inc(hcnt_r) : ZERO;
      if (de_fall_s) begin
        line_w_r <= hcnt_r;
      end else begin
        line_w_r <= line_w_r;
      end
      if (vs_rise_s) begin
        frame_width_r  <= line_w_r;
        frame_height_r <= lcnt_r;
        lcnt_r         <= ZERO;
        frame_valid_r  <= frame_valid_r | (lcnt_r != ZERO);
      end else begin
        lcnt_r <= de_fall_s ? sat_inc(lcnt_r) : lcnt_r;
      end
    end
  end

  // FSM state register
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = xfer_s ? PEND : IDLE;
      PEND:    state_nxt_s = vs_rise_s ? CHECK : PEND;
      CHECK:   state_nxt_s = COMMIT;
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM decoded strobes
  always_comb begin
    xfer_s   = 1'b0;
    check_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE:    xfer_s   = cfg_valid & cfg_ready_r;
      CHECK:   check_s  = 1'b1;
      COMMIT:  commit_s = 1'b1;
      default: xfer_s   = 1'b0;
    endcase
  end

  // Window validation against the frame just measured; left < frame_width is
  // guaranteed before any subtraction result is used
  always_comb begin
    req_w_s   = (p_w_r == ZERO || p_w_r > frame_width_r)  ? frame_width_r  : p_w_r;
    req_h_s   = (p_h_r == ZERO || p_h_r > frame_height_r) ? frame_height_r : p_h_r;
    avail_w_s = (p_left_r < frame_width_r) ? frame_width_r - p_left_r : ZERO;
    avail_h_s = (p_top_r < frame_height_r) ? frame_height_r - p_top_r : ZERO;
    c_top_s   = p_top_r;
    c_left_s  = p_left_r;
    c_w_s     = p_w_r;
    c_h_s     = p_h_r;
    c_err_s   = 1'b0;
    if (frame_valid_r && center_s) begin
      c_w_s    = req_w_s;
      c_h_s    = req_h_s;
      c_left_s = (frame_width_r - req_w_s) >> 1;
      c_top_s  = (frame_height_r - req_h_s) >> 1;
    end else if (frame_valid_r) begin
      c_err_s = (p_left_r >= frame_width_r) || (p_top_r >= frame_height_r);
      c_w_s   = (p_w_r == ZERO || p_w_r > avail_w_s) ? avail_w_s : p_w_r;
      c_h_s   = (p_h_r == ZERO || p_h_r > avail_h_s) ? avail_h_s : p_h_r;
    end else if (center_s) begin
      c_left_s = ZERO;
      c_top_s  = ZERO;
    end else begin
      c_err_s = 1'b0;
    end
  end

  // Pending slot, checked window, committed window and status flags
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      p_top_r <= ZERO;  p_left_r <= ZERO;  p_w_r <= ZERO;  p_h_r <= ZERO;
      p_center_r    <= 1'b0;
      win_top_r <= ZERO; win_left_r <= ZERO; win_w_r <= ZERO; win_h_r <= ZERO;
      win_err_r     <= 1'b0;
      clip_top_r <= ZERO; clip_left_r <= ZERO; clip_w_r <= ZERO; clip_h_r <= ZERO;
      cfg_ready_r   <= 1'b0;
      cfg_pending_r <= 1'b0;
      cfg_err_r     <= 1'b0;
    end else begin
      cfg_ready_r   <= (state_nxt_s == IDLE);
      cfg_pending_r <= (state_nxt_s != IDLE);
      if (xfer_s) begin
        p_top_r  <= cfg_top;
        p_left_r <= cfg_left;
        p_w_r    <= cfg_width;
        p_h_r    <= cfg_height;
`ifdef CLIPPER_WIN_CTRL_CENTER_EN
        p_center_r <= cfg_center;
`else
        p_center_r <= 1'b0;
`endif
      end else begin
        p_center_r <= p_center_r;
      end
      if (check_s) begin
        win_top_r  <= c_top_s;
        win_left_r <= c_left_s;
        win_w_r    <= c_w_s;
        win_h_r    <= c_h_s;
        win_err_r  <= c_err_s;
      end else begin
        win_err_r <= win_err_r;
      end
      if (commit_s && !win_err_r) begin
        clip_top_r  <= win_top_r;
        clip_left_r <= win_left_r;
        clip_w_r    <= win_w_r;
        clip_h_r    <= win_h_r;
      end else begin
        clip_w_r <= clip_w_r;
      end
      // cfg_err is visible during COMMIT; the sticky variant clears on the next write
      if (ERR_HOLD) begin
        if (xfer_s) begin
          cfg_err_r <= 1'b0;
        end else if (check_s && c_err_s) begin
          cfg_err_r <= 1'b1;
        end else begin
          cfg_err_r <= cfg_err_r;
        end
      end else begin
        cfg_err_r <= check_s & c_err_s;
      end
    end
  end

  assign cfg_ready      = cfg_ready_r;
  assign cfg_pending    = cfg_pending_r;
  assign cfg_err        = cfg_err_r;
  assign frame_width    = frame_width_r;
  assign frame_height   = frame_height_r;
  assign frame_valid    = frame_valid_r;
  assign clipper_top    = clip_top_r;
  assign clipper_left   = clip_left_r;
  assign clipper_width  = clip_w_r;
  assign clipper_height = clip_h_r;

endmodule

// File: tb/tb_clipper_win_ctrl.sv
// Directed bench for clipper_win_ctrl. Frames use short 1-pixel lines with a full-width
// last line so that 1920x1080 is measured in a few thousand cycles.
module tb_clipper_win_ctrl;
  localparam int DW = 12;

  logic          pclk, prst_n, invsync, inde, cfg_valid, cfg_ready;
  logic [DW-1:0] cfg_top, cfg_left, cfg_width, cfg_height;
  logic          cfg_center;
  logic [DW-1:0] clipper_top, clipper_left, clipper_width, clipper_height;
  logic [DW-1:0] frame_width, frame_height;
  logic          frame_valid, cfg_pending, cfg_err;
  int            nvec = 0;
  int            nerr = 0;

  clipper_win_ctrl #(.DW(DW), .ERR_HOLD(1'b0)) dut (
    .pclk(pclk), .prst_n(prst_n), .invsync(invsync), .inde(inde),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_top(cfg_top), .cfg_left(cfg_left), .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef CLIPPER_WIN_CTRL_CENTER_EN
    .cfg_center(cfg_center),
`endif
    .clipper_top(clipper_top), .clipper_left(clipper_left),
    .clipper_width(clipper_width), .clipper_height(clipper_height),
    .frame_width(frame_width), .frame_height(frame_height), .frame_valid(frame_valid),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic lines(input int n, input int w);
    for (int i = 0; i < n - 1; i++) begin
      inde = 1'b1; step(1);
      inde = 1'b0; step(1);
    end
    inde = 1'b1; step(w);
    inde = 1'b0; step(3);
  endtask

  task automatic vs_pulse();
    invsync = 1'b1; step(6);
    invsync = 1'b0; step(1);
  endtask

  task automatic write(input int t, input int l, input int w, input int h, input logic c);
    cfg_top = DW'(t); cfg_left = DW'(l); cfg_width = DW'(w); cfg_height = DW'(h);
    cfg_center = c;
    cfg_valid = 1'b1; step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic chk_clip(input string tag, input int t, input int l, input int w, input int h);
    chk({tag, "_top"},    32'(clipper_top),    t);
    chk({tag, "_left"},   32'(clipper_left),   l);
    chk({tag, "_width"},  32'(clipper_width),  w);
    chk({tag, "_height"}, 32'(clipper_height), h);
  endtask

  initial begin
    prst_n = 1'b0; invsync = 1'b0; inde = 1'b0; cfg_valid = 1'b0; cfg_center = 1'b0;
    cfg_top = '0; cfg_left = '0; cfg_width = '0; cfg_height = '0;
    step(3);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk_clip("rst_clip", 0, 0, 0, 0);
    chk("rst_fvalid", 32'(frame_valid), 0);
    chk("rst_pending", 32'(cfg_pending), 0);
    chk("rst_err", 32'(cfg_err), 0);
    prst_n = 1'b1; step(1);
    chk("ready_after_rst", 32'(cfg_ready), 1);

    // first vsync sees no lines yet
    vs_pulse();
    chk("f1_fvalid", 32'(frame_valid), 0);
    lines(1080, 1920);
    vs_pulse();
    chk("f2_fw", 32'(frame_width), 1920);
    chk("f2_fh", 32'(frame_height), 1080);
    chk("f2_fvalid", 32'(frame_valid), 1);
    chk_clip("f2_clip", 0, 0, 0, 0);

    // mid-frame write, commit 3 cycles after the vsync edge
    lines(500, 1);
    chk("wr_ready_before", 32'(cfg_ready), 1);
    write(100, 200, 640, 480, 1'b0);
    chk("wr_ready_after", 32'(cfg_ready), 0);
    chk("wr_pending", 32'(cfg_pending), 1);
    lines(580, 1920);
    chk_clip("pre_vs_clip", 0, 0, 0, 0);
    invsync = 1'b1; step(3);
    chk("lat2_clip_w", 32'(clipper_width), 0);
    chk("lat2_pending", 32'(cfg_pending), 1);
    step(1);
    chk_clip("lat3_clip", 100, 200, 640, 480);
    chk("lat3_pending", 32'(cfg_pending), 0);
    chk("lat3_ready", 32'(cfg_ready), 1);
    step(2); invsync = 1'b0; step(1);

    // clamp at right edge, height 0 = to bottom
    write(1000, 1800, 400, 0, 1'b0);
    lines(1080, 1920);
    vs_pulse();
    chk_clip("clamp_clip", 1000, 1800, 120, 80);

    // left = frame_width is rejected
    write(0, 1920, 10, 10, 1'b0);
    lines(1080, 1920);
    invsync = 1'b1; step(3);
    chk("rej_err_pulse", 32'(cfg_err), 1);
    step(1);
    chk("rej_err_clear", 32'(cfg_err), 0);
    chk("rej_pending", 32'(cfg_pending), 0);
    chk_clip("rej_clip", 1000, 1800, 120, 80);
    step(2); invsync = 1'b0; step(1);

    // second request held while the first is pending
    write(5, 6, 7, 8, 1'b0);
    cfg_top = 12'd9; cfg_left = 12'd10; cfg_width = 12'd11; cfg_height = 12'd12;
    cfg_valid = 1'b1;
    lines(1080, 1920);
    chk("hold_ready", 32'(cfg_ready), 0);
    chk("hold_pending", 32'(cfg_pending), 1);
    invsync = 1'b1; step(4);
    chk_clip("hold_a_clip", 5, 6, 7, 8);
    chk("hold_commit_ready", 32'(cfg_ready), 1);
    step(1);
    chk("hold_b_accepted", 32'(cfg_pending), 1);
    chk("hold_b_ready", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step(1); invsync = 1'b0; step(1);
    lines(1080, 1920);
    vs_pulse();
    chk_clip("hold_b_clip", 9, 10, 11, 12);

    // reset while a write is pending discards it
    write(50, 60, 70, 80, 1'b0);
    chk("prst_pending_before", 32'(cfg_pending), 1);
    lines(100, 5);
    prst_n = 1'b0; #1;
    chk_clip("prst_clip", 0, 0, 0, 0);
    chk("prst_fw", 32'(frame_width), 0);
    chk("prst_fvalid", 32'(frame_valid), 0);
    chk("prst_pending", 32'(cfg_pending), 0);
    chk("prst_ready", 32'(cfg_ready), 0);
    step(2); prst_n = 1'b1; step(1);
    vs_pulse();
    chk("post_rst_fvalid", 32'(frame_valid), 0);
    lines(1080, 1920);
    vs_pulse();
    chk("post_rst_fw", 32'(frame_width), 1920);
    chk("post_rst_pending", 32'(cfg_pending), 0);
    chk_clip("post_rst_clip", 0, 0, 0, 0);

`ifdef CLIPPER_WIN_CTRL_CENTER_EN
    write(7, 7, 640, 480, 1'b1);
    lines(1080, 1920);
    vs_pulse();
    chk_clip("center_clip", 300, 640, 640, 480);
    chk("center_err", 32'(cfg_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
